// File: rtl/palette_converter.sv
// Colour-index to packed {R,G,B} converter backed by a run-time-writable palette.
// Two-stage valid/ready pipeline: stage 1 holds the looked-up entry, stage 2 the attenuated word.
module palette_converter #(
    parameter int IDX_W = 3,
    parameter int DEPTH = 2**IDX_W,
    parameter int CH_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IDX_W-1:0]     colour,
    input  logic [1:0]           dim,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*CH_W-1:0]    rgb,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_addr,
    input  logic [3*CH_W-1:0]    wr_data
);

    localparam int RGB_W = 3*CH_W;

    // Reset palette: bit 2 of the index lights red, bit 1 green, bit 0 blue.
    function automatic logic [RGB_W-1:0] default_entry(input logic [2:0] i);
        logic [RGB_W-1:0] e;
        e = '0;
        if (i[2]) e[3*CH_W-1 -: CH_W] = '1;
        if (i[1]) e[2*CH_W-1 -: CH_W] = '1;
        if (i[0]) e[CH_W-1   -: CH_W] = '1;
        return e;
    endfunction

    logic [RGB_W-1:0] pal_q [DEPTH];
    logic [RGB_W-1:0] pal_d [DEPTH];
    logic             v1_q, v1_d, v2_q, v2_d;
    logic [RGB_W-1:0] ent1_q, ent1_d;
    logic [1:0]       dim1_q, dim1_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    logic             adv1, adv2, accept;
    logic [RGB_W-1:0] rd_entry, shifted;

    assign adv2   = !v2_q || out_ready;
    assign adv1   = enable && (!v1_q || adv2);
    assign accept = in_valid && adv1;

    assign in_ready  = adv1 && rst_n;
    assign out_valid = v2_q;
    assign rgb       = rgb_q;

    always_comb begin
        // Out-of-range indices match no entry and read as zero.
        rd_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (colour == IDX_W'(i)) rd_entry = pal_q[i];
        end

        for (int c = 0; c < 3; c++) begin
            shifted[c*CH_W +: CH_W] = ent1_q[c*CH_W +: CH_W] >> dim1_q;
        end

        for (int i = 0; i < DEPTH; i++) begin
            pal_d[i] = pal_q[i];
            if (wr_en && wr_addr == IDX_W'(i)) pal_d[i] = wr_data;
        end

        v1_d   = v1_q;
        ent1_d = ent1_q;
        dim1_d = dim1_q;
        if (adv1) begin
            v1_d   = accept;
            ent1_d = rd_entry;
            dim1_d = dim;
        end

        // Stage 2 only takes stage 1's content when stage 1 moves; otherwise it drains to a bubble.
        v2_d  = v2_q;
        rgb_d = rgb_q;
        if (adv2) begin
            if (adv1) begin
                v2_d  = v1_q;
                rgb_d = shifted;
            end else begin
                v2_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            ent1_q <= '0;
            dim1_q <= '0;
            rgb_q  <= '0;
            for (int i = 0; i < DEPTH; i++) pal_q[i] <= default_entry(3'(i));
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            ent1_q <= ent1_d;
            dim1_q <= dim1_d;
            rgb_q  <= rgb_d;
            for (int i = 0; i < DEPTH; i++) pal_q[i] <= pal_d[i];
        end
    end

endmodule

// File: tb/tb_palette_converter.sv
// Scoreboard bench for palette_converter: expected words are queued at accept and
// popped at each output handshake, checked against a reference palette model.
module tb_palette_converter;

    localparam int IDX_W = 3;
    localparam int DEPTH = 8;
    localparam int CH_W  = 8;
    localparam int RGB_W = 24;

    logic             clk = 1'b0;
    logic             rst_n, enable, in_valid, in_ready, out_valid, out_ready, wr_en;
    logic [IDX_W-1:0] colour, wr_addr;
    logic [1:0]       dim;
    logic [RGB_W-1:0] rgb, wr_data;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    logic [RGB_W-1:0] mpal [DEPTH];
    logic [RGB_W-1:0] exp_q [$];

    palette_converter #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CH_W(CH_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .colour(colour), .dim(dim),
        .out_valid(out_valid), .out_ready(out_ready), .rgb(rgb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mdef(input int i);
        logic [7:0] r, g, b;
        r = ((i & 4) != 0) ? 8'hFF : 8'h00;
        g = ((i & 2) != 0) ? 8'hFF : 8'h00;
        b = ((i & 1) != 0) ? 8'hFF : 8'h00;
        return {r, g, b};
    endfunction

    function automatic logic [23:0] mlook(input int c, input int d);
        logic [23:0] e;
        logic [7:0]  r, g, b;
        e = mpal[c];
        r = e[23:16] >> d;
        g = e[15:8]  >> d;
        b = e[7:0]   >> d;
        return {r, g, b};
    endfunction

    task automatic mreset();
        for (int i = 0; i < DEPTH; i++) mpal[i] = mdef(i);
        exp_q.delete();
    endtask

    // One clock: sample handshakes just after the falling edge, then update the model at the rising edge.
    task automatic tick(output bit acc);
        logic [RGB_W-1:0] e;
        #1;
        acc = (in_valid && in_ready) === 1'b1;
        if (rst_n && (out_valid && out_ready) === 1'b1) begin
            total++;
            pops++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: rgb=%06h with nothing outstanding", rgb);
            end else begin
                e = exp_q.pop_front();
                if (rgb !== e) begin
                    bad++;
                    $display("FAIL rgb_order: got %06h want %06h", rgb, e);
                end
            end
        end
        if (acc) exp_q.push_back(mlook(int'(colour), int'(dim)));
        @(posedge clk);
        if (!rst_n) mreset();
        else if (wr_en) mpal[wr_addr] = wr_data;
        @(negedge clk);
    endtask

    task automatic feed(input int c, input int d);
        bit a;
        bit got;
        got = 0;
        in_valid = 1'b1;
        colour = IDX_W'(c);
        dim = 2'(d);
        for (int i = 0; i < 30 && !got; i++) begin
            tick(a);
            got = a;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL accept_timeout: colour %0d never accepted, in_ready=%b", c, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit a;
        in_valid = 1'b0;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) tick(a);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d outputs missing, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        bit a;
        rst_n = 1'b0; enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        colour = '0; dim = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick(a);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        tick(a);
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++;
        if (rgb !== 24'h0) begin bad++; $display("FAIL reset_rgb: got %06h want 000000", rgb); end
        rst_n = 1'b1;
        in_valid = 1'b0;
        tick(a);
    endtask

    task automatic test_stream();
        bit a;
        int p0, nacc;
        p0 = pops;
        nacc = 0;
        in_valid = 1'b1; dim = 2'd0; colour = 3'd0;
        tick(a); nacc += a;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early: out_valid=%b one cycle after accept, want 0", out_valid); end
        colour = 3'd1;
        tick(a); nacc += a;
        #1;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL latency_two: out_valid=%b two cycles after accept, want 1", out_valid); end
        for (int c = 2; c < 8; c++) begin
            colour = IDX_W'(c);
            tick(a); nacc += a;
        end
        in_valid = 1'b0;
        tick(a);
        tick(a);
        total++;
        if (nacc != 8) begin bad++; $display("FAIL stream_accepts: got %0d want 8", nacc); end
        total++;
        if (pops - p0 != 8) begin bad++; $display("FAIL stream_throughput: got %0d outputs want 8", pops - p0); end
        drain();
    endtask

    task automatic test_write();
        bit a;
        // same-cycle write and read of entry 3 returns the old contents
        in_valid = 1'b1; colour = 3'd3; dim = 2'd0;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 24'h123456;
        tick(a);
        total++;
        if (!a) begin bad++; $display("FAIL write_same_accept: accepted=%b want 1", a); end
        wr_en = 1'b0;
        tick(a);
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_dim();
        feed(7, 1);
        feed(7, 2);
        feed(7, 3);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 24'h808080;
        feed(5, 3);
        wr_en = 1'b0;
        feed(5, 3);
        drain();
    endtask

    task automatic test_backpressure();
        bit a;
        int c, nacc;
        logic [RGB_W-1:0] held;
        out_ready = 1'b0; in_valid = 1'b1; dim = 2'd0;
        c = 0; nacc = 0;
        for (int i = 0; i < 6; i++) begin
            colour = IDX_W'(c);
            tick(a);
            if (a) begin c++; nacc++; end
        end
        total++;
        if (nacc != 2) begin bad++; $display("FAIL bp_accepts: got %0d want 2", nacc); end
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        total++;
        if (out_valid !== 1'b1 || rgb !== exp_q[0]) begin
            bad++; $display("FAIL bp_head: valid=%b rgb=%06h want 1/%06h", out_valid, rgb, exp_q[0]);
        end
        held = rgb;
        tick(a);
        tick(a);
        total++;
        if (out_valid !== 1'b1 || rgb !== held) begin
            bad++; $display("FAIL bp_stable: valid=%b rgb=%06h want 1/%06h", out_valid, rgb, held);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && c < 5; i++) begin
            colour = IDX_W'(c);
            tick(a);
            if (a) c++;
        end
        total++;
        if (c != 5) begin bad++; $display("FAIL bp_resume: accepted %0d want 5", c); end
        drain();
    endtask

    task automatic test_enable();
        bit a;
        int p0, nacc;
        feed(0, 0);
        feed(1, 0);
        p0 = pops;
        nacc = 0;
        enable = 1'b0; in_valid = 1'b1; colour = 3'd6;
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 24'h010203;
        tick(a); nacc += a;
        wr_en = 1'b0;
        tick(a); nacc += a;
        tick(a); nacc += a;
        total++;
        if (nacc != 0) begin bad++; $display("FAIL enable_accepts: got %0d want 0", nacc); end
        total++;
        if (pops - p0 != 1) begin bad++; $display("FAIL enable_drain: got %0d outputs want 1", pops - p0); end
        enable = 1'b1;
        feed(6, 0);
        feed(2, 1);
        drain();
    endtask

    task automatic test_reset_mid();
        bit a;
        int p0;
        in_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 24'hABCDEF;
        tick(a);
        wr_en = 1'b0;
        feed(1, 0);
        feed(2, 0);
        rst_n = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 24'h111111;
        tick(a);
        wr_en = 1'b0;
        rst_n = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
        p0 = pops;
        for (int i = 0; i < 4; i++) tick(a);
        total++;
        if (pops != p0) begin bad++; $display("FAIL midreset_stale: got %0d outputs want 0", pops - p0); end
        feed(1, 0);
        feed(2, 0);
        drain();
    endtask

    initial begin
        mreset();
        @(negedge clk);
        test_reset();
        test_stream();
        test_write();
        test_dim();
        test_backpressure();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
